gate_sensor_sequencer: RTL and testbench



---
 rtl/gate_sensor_sequencer.sv | 144 ++++++++++++++
 tb/tb_gate_sensor_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sensor_sequencer.sv
// gate_sensor_sequencer
// Plays one scripted turnstile passage per accepted request and drives the
// sensor word {giro, entrada, saida, decMetais} that the turnstile FSM reads.
// Each non-idle word is held for max(HOLD_CYCLES,1) clocks.
// Optional build macro: SEQ_DISPLAY_EN drives a 7-segment digit of the phase;
// without it the display is tied off (all segments dark).
module gate_sensor_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       direcao,
  input  logic       metal,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       giro,
  output logic       entrada,
  output logic       saida,
  output logic       decMetais,
  output logic [2:0] phase,
  output logic [6:0] display
);

  localparam int              HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    PASS    = 3'd2,
    METAL   = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             dir_q, dir_nx;
  logic             metal_q, metal_nx;
  logic [3:0]       word_nx;
  logic             hold_end;

  assign hold_end = (cnt == HOLD_LAST);

  // Next-state, hold counter and request-latch logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; an unassigned path in always_comb infers a latch.
    state_nx = state;
    cnt_nx   = cnt;
    dir_nx   = dir_q;
    metal_nx = metal_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ARM;
          cnt_nx   = '0;
          dir_nx   = direcao;
          metal_nx = metal;
        end
      end
      ARM, PASS, METAL, RELEASE: begin
        if (hold_end) begin
          cnt_nx = '0;
          case (state)
            ARM:     state_nx = PASS;
            PASS:    state_nx = metal_q ? METAL : RELEASE;
            METAL:   state_nx = RELEASE;
            default: state_nx = DONE;
          endcase
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      // Codes 6 and 7 cannot be reached in normal operation; recover to IDLE.
      default: state_nx = IDLE;
    endcase
  end

  // Sensor word for the state being entered, so the outputs can be registered.
  always_comb begin
    word_nx = 4'b0000;
    case (state_nx)
      ARM, RELEASE: word_nx = 4'b1000;
      PASS:         word_nx = dir_nx ? 4'b1010 : 4'b1100;
      METAL:        word_nx = dir_nx ? 4'b1011 : 4'b1101;
      default:      word_nx = 4'b0000;
    endcase
  end

  // State, counter, latched request and all registered outputs.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      dir_q   <= 1'b0;
      metal_q <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      phase   <= 3'd0;
      {giro, entrada, saida, decMetais} <= 4'b0000;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      dir_q   <= dir_nx;
      metal_q <= metal_nx;
      ready   <= (state_nx == IDLE);
      busy    <= (state_nx == ARM) || (state_nx == PASS) ||
                 (state_nx == METAL) || (state_nx == RELEASE);
      done    <= (state_nx == DONE);
      phase   <= state_nx;
      {giro, entrada, saida, decMetais} <= word_nx;
    end
  end

`ifdef SEQ_DISPLAY_EN
  // Phase digit decoder, registered alongside phase (active-low gfedcba).
  always_ff @(posedge clock) begin
    if (!resetn) begin
      display <= 7'b1111111;
    end else begin
      case (state_nx)
        IDLE:    display <= 7'b1000000;
        ARM:     display <= 7'b1111001;
        PASS:    display <= 7'b0100100;
        METAL:   display <= 7'b0110000;
        RELEASE: display <= 7'b0011001;
        DONE:    display <= 7'b0010010;
        default: display <= 7'b1111111;
      endcase
    end
  end
`else
  assign display = 7'b1111111;
`endif

endmodule

// File: tb/tb_gate_sensor_sequencer.sv
// Self-checking bench for gate_sensor_sequencer. Two instances: dut with the
// default hold of 4 and dut0 with HOLD_CYCLES=0 (effective hold 1). Expected
// traces are built from the passage script as phase lists per cycle.
module tb_gate_sensor_sequencer;

  localparam int H = 4;

  logic       clock = 1'b0;
  logic       resetn, start, direcao, metal;
  logic       ready, busy, done, giro, entrada, saida, decMetais;
  logic [2:0] phase;
  logic [6:0] display;

  logic       start0, direcao0, metal0;
  logic       ready0, busy0, done0, giro0, entrada0, saida0, decMetais0;
  logic [2:0] phase0;
  logic [6:0] display0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  gate_sensor_sequencer #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
    .clock(clock), .resetn(resetn), .start(start), .direcao(direcao),
    .metal(metal), .ready(ready), .busy(busy), .done(done), .giro(giro),
    .entrada(entrada), .saida(saida), .decMetais(decMetais),
    .phase(phase), .display(display)
  );

  gate_sensor_sequencer #(.HOLD_CYCLES(0), .CNT_W(8)) dut0 (
    .clock(clock), .resetn(resetn), .start(start0), .direcao(direcao0),
    .metal(metal0), .ready(ready0), .busy(busy0), .done(done0), .giro(giro0),
    .entrada(entrada0), .saida(saida0), .decMetais(decMetais0),
    .phase(phase0), .display(display0)
  );

  // Sensor word the script calls for in a given phase.
  function automatic logic [3:0] word_of(input int ph, input logic d);
    case (ph)
      1, 4:    return 4'b1000;
      2:       return d ? 4'b1010 : 4'b1100;
      3:       return d ? 4'b1011 : 4'b1101;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [6:0] disp_of(input int ph);
`ifdef SEQ_DISPLAY_EN
    case (ph)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      default: return 7'b1111111;
    endcase
`else
    return 7'b1111111;
`endif
  endfunction

  // Expected {word, done, busy, ready, phase, display} for a phase.
  function automatic logic [16:0] expect_of(input int ph, input logic d);
    logic is_busy;
    is_busy = (ph >= 1) && (ph <= 4);
    return {word_of(ph, d), ph == 5, is_busy, ph == 0, 3'(ph), disp_of(ph)};
  endfunction

  function automatic logic [16:0] obs_main();
    return {giro, entrada, saida, decMetais, done, busy, ready, phase, display};
  endfunction

  function automatic logic [16:0] obs_zero();
    return {giro0, entrada0, saida0, decMetais0, done0, busy0, ready0, phase0, display0};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one passage on dut starting from IDLE and compares every cycle up to
  // and including the IDLE cycle after DONE. poke_at re-asserts start (with
  // direcao flipped) in that cycle to prove it is ignored.
  task automatic run_passage(input string name, input logic d, input logic m,
                             input int poke_at);
    int ph_seq[$];
    logic [16:0] exp_v, obs_v;
    ph_seq = {};
    repeat (H) ph_seq.push_back(1);
    repeat (H) ph_seq.push_back(2);
    if (m) repeat (H) ph_seq.push_back(3);
    repeat (H) ph_seq.push_back(4);
    ph_seq.push_back(5);
    ph_seq.push_back(0);
    start = 1'b1; direcao = d; metal = m;
    step();
    foreach (ph_seq[k]) begin
      exp_v = expect_of(ph_seq[k], d);
      obs_v = obs_main();
      n_checks++;
      if (obs_v !== exp_v)
        $display("FAIL %s cycle %0d: got %b required %b", name, k + 1, obs_v, exp_v);
      else
        n_pass++;
      if (k + 1 == poke_at) begin
        start = 1'b1; direcao = ~d; metal = $urandom_range(0, 1);
      end else begin
        start = 1'b0; direcao = 1'($urandom_range(0, 1)); metal = 1'($urandom_range(0, 1));
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] rst_v;
    rst_v = {4'b0000, 1'b0, 1'b0, 1'b1, 3'd0, 7'b1111111};
    resetn = 1'b0; start = 1'b0; direcao = 1'b0; metal = 1'b0;
    start0 = 1'b0; direcao0 = 1'b0; metal0 = 1'b0;
    step(); step();
    n_checks++;
    if (obs_main() !== rst_v) $display("FAIL reset_main: got %b required %b", obs_main(), rst_v);
    else n_pass++;
    n_checks++;
    if (obs_zero() !== rst_v) $display("FAIL reset_hold0: got %b required %b", obs_zero(), rst_v);
    else n_pass++;
    resetn = 1'b1;
    step();
    n_checks++;
    if (obs_main() !== expect_of(0, 1'b0))
      $display("FAIL idle_after_reset: got %b required %b", obs_main(), expect_of(0, 1'b0));
    else n_pass++;
  endtask

  task automatic test_scripted();
    run_passage("entry_no_metal", 1'b0, 1'b0, -1);
    run_passage("entry_metal",    1'b0, 1'b1, -1);
    run_passage("exit_metal",     1'b1, 1'b1, -1);
    run_passage("exit_no_metal",  1'b1, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    run_passage("start_while_busy", 1'b0, 1'b0, 6);
    run_passage("start_in_done",    1'b1, 1'b0, 3 * H + 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_passage("random_passage", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
  endtask

  task automatic test_reset_mid();
    int extra_done;
    start = 1'b1; direcao = 1'b0; metal = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    n_checks++;
    if (phase !== 3'd2) $display("FAIL abort_setup_phase: got %0d required 2", phase);
    else n_pass++;
    resetn = 1'b0;
    step();
    n_checks++;
    if (obs_main() !== {4'b0000, 1'b0, 1'b0, 1'b1, 3'd0, 7'b1111111})
      $display("FAIL abort_state: got %b required %b", obs_main(),
               {4'b0000, 1'b0, 1'b0, 1'b1, 3'd0, 7'b1111111});
    else n_pass++;
    resetn = 1'b1;
    extra_done = 0;
    repeat (4 * H + 4) begin
      step();
      if (done === 1'b1 || ready !== 1'b1) extra_done++;
    end
    n_checks++;
    if (extra_done != 0) $display("FAIL abort_no_done: got %0d bad cycles required 0", extra_done);
    else n_pass++;
    run_passage("after_abort", 1'b1, 1'b0, -1);
  endtask

  task automatic test_back_to_back_hold0();
    int seq[$];
    int dones;
    logic d0, m0;
    logic [16:0] exp_v;
    d0 = 1'($urandom_range(0, 1));
    m0 = 1'($urandom_range(0, 1));
    seq = {1, 2};
    if (m0) seq.push_back(3);
    seq.push_back(4);
    seq.push_back(5);
    seq.push_back(0);
    start0 = 1'b1; direcao0 = d0; metal0 = m0;
    step();
    dones = 0;
    for (int k = 0; k < 3 * seq.size(); k++) begin
      exp_v = expect_of(seq[k % seq.size()], d0);
      n_checks++;
      if (obs_zero() !== exp_v)
        $display("FAIL hold0_b2b cycle %0d: got %b required %b", k + 1, obs_zero(), exp_v);
      else n_pass++;
      if (done0 === 1'b1) dones++;
      step();
    end
    start0 = 1'b0;
    n_checks++;
    if (dones != 3) $display("FAIL hold0_done_count: got %0d required 3", dones);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_scripted();
    test_start_ignored();
    test_random();
    test_reset_mid();
    test_back_to_back_hold0();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
